// File: rtl/cordic_pkg.sv
// Shared types and the quadrant unfold helper for the CORDIC angle front/back stage.
// Full-circle angle width is ASIZE + QUAD_BITS.
package cordic_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  typedef struct packed {
    logic      valid;
    quadrant_t quad;
  } tag_t;

  localparam int unsigned QUAD_BITS = 2;
  localparam int unsigned ANG_MAX_W = 32;
  localparam int unsigned UNF_W     = ANG_MAX_W + QUAD_BITS;

  // a is the first-quadrant angle (full scale 2^asize = 90deg); result is mod 2^(asize+2).
  function automatic logic [UNF_W-1:0] unfold_angle(
    input quadrant_t              quad,
    input logic [ANG_MAX_W-1:0]   a,
    input int unsigned            asize
  );
    logic [UNF_W-1:0] one;
    logic [UNF_W-1:0] h;
    logic [UNF_W-1:0] ax;
    logic [UNF_W-1:0] r;
    one = {{(UNF_W-1){1'b0}}, 1'b1};
    h   = one << asize;
    ax  = {{QUAD_BITS{1'b0}}, a};
    case (quad)
      Q0:      r = ax;
      Q1:      r = (h << 1) - ax;
      Q2:      r = (h << 1) + ax;
      default: r = (h << 2) - ax;
    endcase
    return r & ((h << 2) - one);
  endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two.
// rd_data reads as zero while empty.
module cordic_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 18
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_rd;

  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign valid   = (count_q != '0);
  assign rd_data = valid ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

  // Upstream credit accounting guarantees this never fires.
  a_no_overflow : assert property (@(posedge clock) disable iff (!rst_n)
    !(wr_en && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/xy_quadrant_ctrl.sv
// Fold/unfold wrapper around a first-quadrant CORDIC angle core with credit-based back-pressure.
// Optional macro XY_ZERO_FLAG_EN adds out_zero and forces the angle of (0,0) samples to 0.
module xy_quadrant_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned DSIZE      = 16,
  parameter int unsigned ASIZE      = 16,
  parameter int unsigned CORE_LAT   = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DSIZE-1:0]     in_x,
  input  logic [DSIZE-1:0]     in_y,
  output logic [DSIZE-1:0]     core_x,
  output logic [DSIZE-1:0]     core_y,
  input  logic [ASIZE-1:0]     core_angle,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ASIZE+1:0]     out_angle
`ifdef XY_ZERO_FLAG_EN
  ,
  output logic                 out_zero
`endif
);

  localparam int unsigned OW  = ASIZE + QUAD_BITS;
  localparam int unsigned CRW = $clog2(FIFO_DEPTH + 1);
`ifdef XY_ZERO_FLAG_EN
  localparam int unsigned FW  = OW + 1;
`else
  localparam int unsigned FW  = OW;
`endif

  logic                 accept;
  logic                 pop;
  logic [DSIZE-1:0]     x_abs, y_abs;
  quadrant_t            quad;

  logic [DSIZE-1:0]     core_x_q, core_x_d;
  logic [DSIZE-1:0]     core_y_q, core_y_d;
  tag_t                 fold_tag_q, fold_tag_d;
  tag_t [CORE_LAT-1:0]  sr_q, sr_d;
  logic                 u_valid_q, u_valid_d;
  logic [OW-1:0]        u_angle_q, u_angle_d;
  logic [CRW-1:0]       credits_q, credits_d;

  logic [FW-1:0]        fifo_wdata;
  logic [FW-1:0]        fifo_rdata;
  logic [CRW-1:0]       fifo_count;

`ifdef XY_ZERO_FLAG_EN
  logic                 zero_fold_q, zero_fold_d;
  logic [CORE_LAT-1:0]  zero_sr_q, zero_sr_d;
  logic                 u_zero_q, u_zero_d;
`endif

  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign in_ready = (credits_q != '0);

  // Fold: magnitude is taken as unsigned so -2^(DSIZE-1) maps to 2^(DSIZE-1).
  always_comb begin
    x_abs = in_x[DSIZE-1] ? (~in_x + DSIZE'(1)) : in_x;
    y_abs = in_y[DSIZE-1] ? (~in_y + DSIZE'(1)) : in_y;
    case ({in_x[DSIZE-1], in_y[DSIZE-1]})
      2'b00:   quad = Q0;
      2'b10:   quad = Q1;
      2'b11:   quad = Q2;
      default: quad = Q3;
    endcase
    core_x_d         = accept ? x_abs : core_x_q;
    core_y_d         = accept ? y_abs : core_y_q;
    fold_tag_d.valid = accept;
    fold_tag_d.quad  = quad;
  end

  // Tag pipeline mirrors the core latency so sr_q[CORE_LAT-1] lines up with core_angle.
  always_comb begin
    sr_d[0] = fold_tag_q;
    for (int i = 1; i < CORE_LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

`ifdef XY_ZERO_FLAG_EN
  always_comb begin
    zero_fold_d  = accept && (in_x == '0) && (in_y == '0);
    zero_sr_d[0] = zero_fold_q;
    for (int i = 1; i < CORE_LAT; i++) begin
      zero_sr_d[i] = zero_sr_q[i-1];
    end
    u_zero_d = zero_sr_q[CORE_LAT-1];
  end
`endif

  always_comb begin
    u_valid_d = sr_q[CORE_LAT-1].valid;
    u_angle_d = OW'(unfold_angle(sr_q[CORE_LAT-1].quad, ANG_MAX_W'(core_angle), ASIZE));
`ifdef XY_ZERO_FLAG_EN
    if (zero_sr_q[CORE_LAT-1]) begin
      u_angle_d = '0;
    end
`endif
  end

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) begin
      credits_d = credits_q - CRW'(1);
    end else if (pop && !accept) begin
      credits_d = credits_q + CRW'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      core_x_q   <= '0;
      core_y_q   <= '0;
      fold_tag_q <= '0;
      sr_q       <= '0;
      u_valid_q  <= 1'b0;
      u_angle_q  <= '0;
      credits_q  <= CRW'(FIFO_DEPTH);
    end else begin
      core_x_q   <= core_x_d;
      core_y_q   <= core_y_d;
      fold_tag_q <= fold_tag_d;
      sr_q       <= sr_d;
      u_valid_q  <= u_valid_d;
      u_angle_q  <= u_angle_d;
      credits_q  <= credits_d;
    end
  end

`ifdef XY_ZERO_FLAG_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      zero_fold_q <= 1'b0;
      zero_sr_q   <= '0;
      u_zero_q    <= 1'b0;
    end else begin
      zero_fold_q <= zero_fold_d;
      zero_sr_q   <= zero_sr_d;
      u_zero_q    <= u_zero_d;
    end
  end

  assign fifo_wdata = {u_zero_q, u_angle_q};
  assign out_zero   = fifo_rdata[OW];
`else
  assign fifo_wdata = u_angle_q;
`endif

  cordic_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clock   (clock),
    .rst_n   (rst_n),
    .wr_en   (u_valid_q),
    .wr_data (fifo_wdata),
    .rd_en   (out_ready),
    .rd_data (fifo_rdata),
    .valid   (out_valid),
    .count   (fifo_count)
  );

  assign core_x    = core_x_q;
  assign core_y    = core_y_q;
  assign out_angle = fifo_rdata[OW-1:0];

  a_credit_bound : assert property (@(posedge clock) disable iff (!rst_n)
    (32'(credits_q) + 32'(fifo_count) <= FIFO_DEPTH));

endmodule

// File: tb/tb_xy_quadrant_ctrl.sv
// Randomized bench for xy_quadrant_ctrl with an ideal CORDIC core and an atan2 scoreboard.
// Build with XY_ZERO_FLAG_EN defined to exercise out_zero.
module tb_xy_quadrant_ctrl;

  localparam int     DSIZE      = 16;
  localparam int     ASIZE      = 16;
  localparam int     CORE_LAT   = 8;
  localparam int     FIFO_DEPTH = 16;
  localparam int     OW         = ASIZE + 2;
  localparam longint FULL       = longint'(1) << OW;
  localparam real    PI         = 3.14159265358979323846;

  logic              clock     = 1'b0;
  logic              rst_n     = 1'b1;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [DSIZE-1:0]  in_x      = '0;
  logic [DSIZE-1:0]  in_y      = '0;
  logic [DSIZE-1:0]  core_x;
  logic [DSIZE-1:0]  core_y;
  logic [ASIZE-1:0]  core_angle;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OW-1:0]     out_angle;
`ifdef XY_ZERO_FLAG_EN
  logic              out_zero;
`endif

  int     checks   = 0;
  int     errors   = 0;
  int     accepted = 0;
  int     n_out    = 0;
  longint exp_q[$];
  bit     expz_q[$];

  always #5 clock = ~clock;

  xy_quadrant_ctrl #(
    .DSIZE      (DSIZE),
    .ASIZE      (ASIZE),
    .CORE_LAT   (CORE_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_angle (core_angle),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_angle  (out_angle)
`ifdef XY_ZERO_FLAG_EN
    ,
    .out_zero   (out_zero)
`endif
  );

  // Ideal first-quadrant core: rounded atan2(|y|,|x|), 2^ASIZE = 90deg, saturated below 90deg.
  function automatic logic [ASIZE-1:0] ideal_angle(input logic [DSIZE-1:0] x, input logic [DSIZE-1:0] y);
    real    r;
    longint v;
    r = $atan2(real'(y), real'(x)) / (PI / 2.0) * real'(longint'(1) << ASIZE);
    v = longint'(r);
    if (v > (longint'(1) << ASIZE) - 1) v = (longint'(1) << ASIZE) - 1;
    return v[ASIZE-1:0];
  endfunction

  logic [ASIZE-1:0] core_pipe [CORE_LAT];
  always @(posedge clock) begin
    core_pipe[0] <= ideal_angle(core_x, core_y);
    for (int i = 1; i < CORE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_angle = core_pipe[CORE_LAT-1];

  // Reference: full-circle angle straight from signed atan2, 2^OW = 360deg.
  function automatic longint ref_angle(input int x, input int y);
    real    r;
    longint v;
    r = $atan2(real'(y), real'(x));
    if (r < 0.0) r = r + 2.0 * PI;
    v = longint'(r / (2.0 * PI) * real'(FULL));
    return v % FULL;
  endfunction

  task automatic check(input string tag, input longint got, input longint exp, input longint tol, input longint m);
    longint d;
    checks++;
    d = got - exp;
    if (m != 0) begin
      d = d % m;
      if (d < 0) d = d + m;
      if (d > m / 2) d = m - d;
    end else if (d < 0) begin
      d = -d;
    end
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Monitor/scoreboard: sampled on the falling edge, away from DUT updates.
  always @(negedge clock) begin
    if (!rst_n) begin
      exp_q.delete();
      expz_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_angle(int'($signed(in_x)), int'($signed(in_y))));
        expz_q.push_back((in_x == '0) && (in_y == '0));
        accepted++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0, 0, 0);
        end else begin
          check(out_ready ? "angle" : "held_angle", longint'(out_angle), exp_q[0], 4, FULL);
`ifdef XY_ZERO_FLAG_EN
          check("zero_flag", longint'(out_zero), longint'(expz_q[0]), 0, 0);
          if (expz_q[0]) check("zero_angle", longint'(out_angle), 0, 0, 0);
`endif
          if (out_ready) begin
            $display("out %0d: angle=0x%05h expected=0x%05h", n_out, out_angle, exp_q[0]);
            void'(exp_q.pop_front());
            void'(expz_q.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  task automatic send_one(input int x, input int y, output int lat,
                          output logic [DSIZE-1:0] cx, output logic [DSIZE-1:0] cy);
    int n;
    n        = 0;
    in_x     = x[DSIZE-1:0];
    in_y     = y[DSIZE-1:0];
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 0, 1, 0, 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    cx = core_x;
    cy = core_y;
    n  = 0;
    while (!out_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    lat = n;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    repeat (3) @(posedge clock);
    #1;
    check(tag, longint'(exp_q.size()), 0, 0, 0);
  endtask

  function automatic int rand_coord();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 65535)) - 32768;
      1:       return int'($urandom_range(0, 200)) - 100;
      2:       return 0;
      default: return ($urandom_range(0, 1) == 1) ? -32768 : 32767;
    endcase
  endfunction

  initial begin
    int               lat;
    int               acc0;
    logic [DSIZE-1:0] cx, cy;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", longint'(in_ready), 1, 0, 0);
    check("rst_out_valid", longint'(out_valid), 0, 0, 0);
    check("rst_core_x", longint'(core_x), 0, 0, 0);
    check("rst_core_y", longint'(core_y), 0, 0, 0);
    check("rst_out_angle", longint'(out_angle), 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b1;

    // Single sample on +X axis, latency measured from the accepting edge.
    send_one(1000, 0, lat, cx, cy);
    check("latency", longint'(lat), CORE_LAT + 2, 0, 0);
    check("core_x_1000", longint'(cx), 1000, 0, 0);

    send_one(-1000, 0, lat, cx, cy);
    send_one(0, -1000, lat, cx, cy);
    send_one(-707, -707, lat, cx, cy);
    check("core_y_707", longint'(cy), 707, 0, 0);

    // Most negative X folds to 2^(DSIZE-1) without saturation.
    send_one(-32768, -1, lat, cx, cy);
    check("corner_core_x", longint'(cx), 32'h8000, 0, 0);
    check("corner_core_y", longint'(cy), 1, 0, 0);
    wait_drain("directed_drain");

    send_one(0, 0, lat, cx, cy);
    send_one(5, 5, lat, cx, cy);
    wait_drain("zero_drain");

    // Back-pressure: credits admit exactly FIFO_DEPTH samples.
    out_ready = 1'b0;
    acc0      = accepted;
    in_valid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_x = DSIZE'(rand_coord());
      in_y = DSIZE'(rand_coord());
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("fill_accepts", longint'(accepted - acc0), FIFO_DEPTH, 0, 0);
    check("fill_in_ready", longint'(in_ready), 0, 0, 0);
    out_ready = 1'b1;
    wait_drain("fill_drain");
    check("fill_credits_back", longint'(in_ready), 1, 0, 0);

    // Reset with results buffered: they must vanish.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_x     = DSIZE'(rand_coord());
      in_y     = DSIZE'(rand_coord());
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    check("pre_rst_out_valid", longint'(out_valid), 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", longint'(out_valid), 0, 0, 0);
    check("mid_rst_out_angle", longint'(out_angle), 0, 0, 0);
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", longint'(in_ready), 1, 0, 0);
    out_ready = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    check("post_rst_out_valid", longint'(out_valid), 0, 0, 0);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_x      = DSIZE'(rand_coord());
      in_y      = DSIZE'(rand_coord());
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand_drain");
    check("final_in_ready", longint'(in_ready), 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
